ccta_arbiter: RTL and testbench
===============================

CCTA_ARBITER -- requirements
Module: ccta_arbiter

Interface
REQ-001 The block SHALL have parameter: W, 4, operand width; result width is W+1.
REQ-002 The block SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have ports: req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 The block SHALL have ports: op0, op1  input  1 each  operation select; 0 = A+B, 1 = A-C.
REQ-006 The block SHALL have ports: a0, b0, c0, a1, b1, c1  input  W each  operands per requester.
REQ-007 The block SHALL have ports: gnt0, gnt1  output  1 each  accept strobe, combinational from state and requests.
REQ-008 The block SHALL have port: rsp_valid  output  1  result available.
REQ-009 The block SHALL have port: rsp_ready  input  1  consumer takes result.
REQ-010 The block SHALL have port: rsp_data  output  W+1  registered result.
REQ-011 The block SHALL have port: rsp_id  output  1  requester that owns rsp_data.
REQ-012 The block SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, EXEC and RESP.
REQ-014 In IDLE with at least one req high, the block SHALL assert exactly one gnt for one cycle; req&gnt in that cycle is the accept.
REQ-015 On accept, the block SHALL latch that requester's op, a, b, c and id, then go to EXEC.
REQ-016 Arbitration SHALL be round-robin: on simultaneous req0 and req1, grant the requester not granted last; with a single req, grant it regardless of history.
REQ-017 In EXEC, the block SHALL drive the latched operands into the add/sub datapath and register the result into rsp_data and the id into rsp_id, then go to RESP.
REQ-018 op=0 SHALL produce a+b zero-extended to W+1 bits with the carry in the MSB.
REQ-019 op=1 SHALL produce a-c modulo 2^(W+1), two's complement, with no saturation; for W=4, 2-5 gives 5'b11101.
REQ-020 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL be held stable until rsp_ready is sampled high.
REQ-021 On rsp_valid&rsp_ready, the block SHALL return to IDLE; no new grant SHALL occur in that same cycle.
REQ-022 Latency SHALL be: accept in cycle N, rsp_valid high from cycle N+2; with rsp_ready held high, minimum issue interval is 3 cycles.
REQ-023 gnt0 and gnt1 SHALL be 0 in EXEC and RESP; requests are not queued and requesters hold req until granted.
REQ-024 Operand changes after accept SHALL NOT affect the in-flight result.
REQ-025 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-026 On rst_n=0 at a rising edge, the block SHALL set state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0 and busy=0, and the round-robin pointer SHALL favour requester 0 next.
REQ-027 Reset asserted in EXEC or RESP SHALL abort the operation and discard its result; rsp_valid SHALL be 0 from the next cycle.
REQ-028 While rst_n=0, gnt0 and gnt1 SHALL be 0.

Structure
REQ-029 The state encoding enum and the op encodings OP_ADD=0 and OP_SUB=1 SHALL reside in shared package ccta_pkg.
REQ-030 The add/sub datapath SHALL be a separate combinational sub-module addsub_unit (inputs a, b, c, op; output W+1 result), instantiated once.
REQ-031 All registers SHALL be in one clocked process; gnt SHALL be the only combinational outputs.

Verification
REQ-032 A bench SHALL cover: single add: req0, op0=0, a0=9, b0=8 -> gnt0 in cycle N, rsp_valid at N+2, rsp_data=17, rsp_id=0.
REQ-033 A bench SHALL cover: subtract wrap: req1, op1=1, a1=2, c1=5 -> rsp_data=5'b11101, rsp_id=1.
REQ-034 A bench SHALL cover: contention: req0 and req1 held high with rsp_ready=1 -> grants alternate 0,1,0,1 starting at 0 after reset, 3 cycles apart.
REQ-035 A bench SHALL cover: backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_id stable, no gnt; ready=1 -> IDLE next cycle.
REQ-036 A bench SHALL cover: operand change: a0 changed from 15 to 0 in the cycle after accept of 15+15 -> rsp_data=30.
REQ-037 A bench SHALL cover: mid-op reset: rst_n=0 for one cycle during EXEC -> rsp_valid never asserts for that op, busy=0, next contention grants requester 0.

Source files
------------

// File: rtl/ccta_pkg.sv
// Shared types for the two-requester add/sub arbiter.
// Holds FSM state encoding and operation selects.
package ccta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/ccta_arbiter_addsub.sv
// Combinational add/sub datapath: a+b or a-c,
// both produced at W+1 bits.
module addsub_unit
    import ccta_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic         op,
    output logic [W:0]   result
);

    always_comb begin
        if (op == OP_SUB) begin
            result = {1'b0, a} - {1'b0, c};
        end else begin
            result = {1'b0, a} + {1'b0, b};
        end
    end

endmodule

// File: rtl/ccta_arbiter.sv
// Round-robin arbiter sharing one add/sub unit
// between two requesters, one operation in flight.
module ccta_arbiter
    import ccta_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         op0,
    input  logic         op1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] c0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic [W-1:0] c1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W:0]   rsp_data,
    output logic         rsp_id,
    output logic         busy
);

    state_t       state;
    state_t       state_nx;
    logic         last_id;
    logic         op_q;
    logic         id_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] c_q;
    logic [W:0]   res;

    addsub_unit #(.W(W)) u_addsub (
        .a      (a_q),
        .b      (b_q),
        .c      (c_q),
        .op     (op_q),
        .result (res)
    );

    // last_id=1 means requester 0 wins the next tie
    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n && (req0 || req1)) begin
                    if (req0 && (!req1 || last_id)) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt1 = 1'b1;
                    end
                    state_nx = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            busy      <= 1'b0;
            last_id   <= 1'b1;
            op_q      <= OP_ADD;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
        end else begin
            state <= state_nx;
            if (gnt0 || gnt1) begin
                op_q    <= gnt1 ? op1 : op0;
                a_q     <= gnt1 ? a1 : a0;
                b_q     <= gnt1 ? b1 : b0;
                c_q     <= gnt1 ? c1 : c0;
                id_q    <= gnt1;
                last_id <= gnt1;
                busy    <= 1'b1;
            end
            if (state == EXEC) begin
                rsp_data  <= res;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ccta_arbiter.sv
// Self-checking bench for ccta_arbiter: directed
// scenarios plus random traffic against a reference model.
module tb_ccta_arbiter;

    localparam int W = 4;
    localparam int M = 1 << (W + 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic         op0 = 1'b0;
    logic         op1 = 1'b0;
    logic [W-1:0] a0 = '0;
    logic [W-1:0] b0 = '0;
    logic [W-1:0] c0 = '0;
    logic [W-1:0] a1 = '0;
    logic [W-1:0] b1 = '0;
    logic [W-1:0] c1 = '0;
    logic         gnt0;
    logic         gnt1;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W:0]   rsp_data;
    logic         rsp_id;
    logic         busy;

    ccta_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .b0        (b0),
        .c0        (c0),
        .a1        (a1),
        .b1        (b1),
        .c1        (c1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // reference model: occupancy, pending result, held response
    bit m_busy = 0;
    bit m_valid = 0;
    int m_data = 0;
    bit m_id = 0;
    bit m_last = 1;
    int m_pend = 0;
    bit m_pid = 0;
    bit e0_q = 0;
    bit e1_q = 0;

    int gq_id[$];
    int gq_cyc[$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int calc(bit op, int a, int b, int c);
        int r;
        r = op ? (a - c) : (a + b);
        return ((r % M) + M) % M;
    endfunction

    task automatic cycle();
        bit e0;
        bit e1;
        @(negedge clk);
        e0 = rst_n && !m_busy && req0 && (!req1 || m_last);
        e1 = rst_n && !m_busy && req1 && (!req0 || !m_last);
        chk("gnt0", gnt0, e0);
        chk("gnt1", gnt1, e1);
        chk("gnt_excl", gnt0 & gnt1, 0);
        chk("busy", busy, m_busy);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", rsp_id, m_id);
        if (gnt0) begin
            gq_id.push_back(0);
            gq_cyc.push_back(cyc);
        end
        if (gnt1) begin
            gq_id.push_back(1);
            gq_cyc.push_back(cyc);
        end
        e0_q = e0;
        e1_q = e1;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_valid = 0;
            m_data = 0; m_id = 0; m_last = 1;
        end else if (m_valid) begin
            if (rsp_ready) begin
                m_valid = 0; m_busy = 0;
            end
        end else if (m_busy) begin
            m_valid = 1; m_data = m_pend; m_id = m_pid;
        end else if (e0 || e1) begin
            m_busy = 1;
            m_pid = e1;
            m_last = e1;
            m_pend = e1 ? calc(op1, a1, b1, c1)
                        : calc(op0, a0, b0, c0);
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input int n);
        req0 = 0; req1 = 0; rsp_ready = 1;
        repeat (n) cycle();
    endtask

    int sd;
    int sid;
    int n0;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // reset values
        cycle();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rsp_data, 0);
        rst_n = 1;
        cycle();

        // single add 9+8
        req0 = 1; op0 = 0; a0 = 9; b0 = 8;
        gq_id.delete(); gq_cyc.delete();
        cycle();
        n0 = cyc - 1;
        chk("add_gnt", gq_id.size() > 0 ? gq_id[0] : 9, 0);
        req0 = 0; a0 = 0; b0 = 0;
        cycle();
        chk("add_valid", rsp_valid, 1);
        chk("add_lat", cyc - n0, 2);
        chk("add_data", rsp_data, 17);
        chk("add_id", rsp_id, 0);
        drain(2);

        // subtract wrap 2-5
        req1 = 1; op1 = 1; a1 = 2; c1 = 5; b1 = 7;
        cycle();
        req1 = 0;
        cycle();
        chk("sub_data", rsp_data, 5'b11101);
        chk("sub_id", rsp_id, 1);
        drain(2);

        // contention after reset
        rst_n = 0; cycle(); rst_n = 1;
        req0 = 1; req1 = 1; op0 = 0; op1 = 0;
        gq_id.delete(); gq_cyc.delete();
        repeat (12) cycle();
        chk("cont_n", gq_id.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_id", i < gq_id.size() ? gq_id[i] : 9, i % 2);
            if (i > 0 && i < gq_cyc.size())
                chk("cont_gap", gq_cyc[i] - gq_cyc[i-1], 3);
        end
        drain(3);

        // backpressure
        req0 = 1; op0 = 0; a0 = 3; b0 = 4; rsp_ready = 0;
        cycle();
        req0 = 0;
        cycle();
        sd = rsp_data; sid = rsp_id;
        chk("bp_first", sd, 7);
        req1 = 1;
        repeat (5) begin
            cycle();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, sd);
            chk("bp_id", rsp_id, sid);
            chk("bp_gnt", gnt0 | gnt1, 0);
        end
        req1 = 0; rsp_ready = 1;
        cycle();
        chk("bp_idle", busy, 0);
        drain(1);

        // operand change after accept
        req0 = 1; op0 = 0; a0 = 15; b0 = 15;
        cycle();
        req0 = 0; a0 = 0;
        cycle();
        chk("opchg_data", rsp_data, 30);
        drain(2);

        // reset during EXEC
        req0 = 1; op0 = 0; a0 = 1; b0 = 1;
        cycle();
        req0 = 0; rst_n = 0;
        cycle();
        rst_n = 1;
        repeat (3) begin
            cycle();
            chk("mid_valid", rsp_valid, 0);
            chk("mid_busy", busy, 0);
        end
        req0 = 1; req1 = 1;
        gq_id.delete(); gq_cyc.delete();
        cycle();
        chk("mid_rr", gq_id.size() > 0 ? gq_id[0] : 9, 0);
        drain(3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (req0 && e0_q) req0 = 0;
            else if (!req0) req0 = ($urandom % 3) == 0;
            if (req1 && e1_q) req1 = 0;
            else if (!req1) req1 = ($urandom % 3) == 0;
            op0 = $urandom % 2; op1 = $urandom % 2;
            a0 = $urandom; b0 = $urandom; c0 = $urandom;
            a1 = $urandom; b1 = $urandom; c1 = $urandom;
            rsp_ready = ($urandom % 4) != 0;
            rst_n = ($urandom % 97) != 0;
            if (!rst_n) begin
                req0 = 0; req1 = 0;
            end
            cycle();
        end
        rst_n = 1;
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
